// File: rtl/pw_pkg.sv
// Shared constants for the button-password checker: symbol codes, widths, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pw_pkg;

    localparam int SYM_W = 3;

    localparam logic [SYM_W-1:0] SYM_NONE = 3'd0;
    localparam logic [SYM_W-1:0] SYM_L    = 3'd1;
    localparam logic [SYM_W-1:0] SYM_R    = 3'd2;
    localparam logic [SYM_W-1:0] SYM_U    = 3'd3;
    localparam logic [SYM_W-1:0] SYM_D    = 3'd4;
    localparam logic [SYM_W-1:0] SYM_C    = 3'd5;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t COLLECT = 2'd1;
    localparam state_t CHECK   = 2'd2;
    localparam state_t LOCKOUT = 2'd3;

    // Only L..C are real buttons; 0 with an edge and 6/7 are garbage symbols.
    function automatic logic sym_legal(input logic [SYM_W-1:0] s);
        return (s >= SYM_L) && (s <= SYM_C);
    endfunction

endpackage

// File: rtl/pw_edge_sync.sv
// Two-flop synchronizer for the button code and press level, plus rising-edge strobe.
// Latency: press_stb/sym valid 2 clk after the input change (captured downstream on the 3rd edge).
// Backpressure: none; one strobe per press, holding or releasing generates nothing further.
module pw_edge_sync
    import pw_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] pwinput,
    input  logic             pw_entered,
    output logic             press_stb,
    output logic [SYM_W-1:0] sym
);

    logic [SYM_W-1:0] sym_s1;
    logic [SYM_W-1:0] sym_s2;
    logic             ent_s1;
    logic             ent_s2;
    logic             ent_d;

    // Synchronize code and level together so the code lines up with the level edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_s1 <= '0;
            sym_s2 <= '0;
            ent_s1 <= 1'b0;
            ent_s2 <= 1'b0;
            ent_d  <= 1'b0;
        end else begin
            sym_s1 <= pwinput;
            sym_s2 <= sym_s1;
            ent_s1 <= pw_entered;
            ent_s2 <= ent_s1;
            ent_d  <= ent_s2;
        end
    end

    assign press_stb = ent_s2 & ~ent_d;
    assign sym       = sym_s2;

endmodule

// File: rtl/pw_check.sv
// Collects PW_LEN button symbols, checks them against PW_CODE, reports pass/fail, locks out after MAX_FAIL misses.
// Latency: symbol captured 3 clk after input change; pw_ok/pw_fail pulse 1 clk after the last capture.
// Backpressure: none; presses during CHECK/LOCKOUT are dropped. Optional inter-press timeout under PW_TIMEOUT_EN.
module pw_check
    import pw_pkg::*;
#(
    parameter int                      PW_LEN         = 4,
    parameter logic [SYM_W*PW_LEN-1:0] PW_CODE        = 12'b101_011_010_001,
    parameter int                      MAX_FAIL       = 3,
    parameter logic [31:0]             LOCK_CYCLES    = 32'd500_000_000,
    parameter logic [31:0]             TIMEOUT_CYCLES = 32'd300_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] pwinput,
    input  logic             pw_entered,
    input  logic             clear,
    output logic             pw_ok,
    output logic             pw_fail,
    output logic             locked,
    output logic [3:0]       digit_cnt,
    output logic [2:0]       fail_cnt
);

    state_t                  state;
    logic                    match;
    logic [31:0]             lock_cnt;
    logic                    press_stb;
    logic [SYM_W-1:0]        sym;
    logic [SYM_W*PW_LEN-1:0] code_sh;
    logic [SYM_W-1:0]        exp_sym;
    logic                    sym_hit;
    logic                    last_fail;
    logic [2:0]              fail_inc;
    logic                    last_sym;

    pw_edge_sync u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwinput    (pwinput),
        .pw_entered (pw_entered),
        .press_stb  (press_stb),
        .sym        (sym)
    );

    // digit_cnt is 0 in IDLE, so it indexes the expected slice for both the first and later presses.
    assign code_sh   = PW_CODE >> (SYM_W * int'(digit_cnt));
    assign exp_sym   = code_sh[SYM_W-1:0];
    assign sym_hit   = sym_legal(sym) && (sym == exp_sym);
    assign last_sym  = (digit_cnt + 4'd1) == 4'(PW_LEN);
    assign last_fail = (fail_cnt + 3'd1) == 3'(MAX_FAIL);
    assign fail_inc  = (fail_cnt >= 3'(MAX_FAIL)) ? 3'(MAX_FAIL) : fail_cnt + 3'd1;
    assign locked    = (state == LOCKOUT);

`ifdef PW_TIMEOUT_EN
    logic [31:0] tmo_cnt;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = TIMEOUT_CYCLES;
`endif

    // Main attempt FSM: running compare, result pulses, failure counting and lockout timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            match     <= 1'b0;
            digit_cnt <= '0;
            fail_cnt  <= '0;
            lock_cnt  <= '0;
            pw_ok     <= 1'b0;
            pw_fail   <= 1'b0;
`ifdef PW_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            pw_ok   <= 1'b0;
            pw_fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        digit_cnt <= '0;
                    end else if (press_stb) begin
                        digit_cnt <= 4'd1;
                        match     <= sym_hit;
                        state     <= (PW_LEN == 1) ? CHECK : COLLECT;
`ifdef PW_TIMEOUT_EN
                        tmo_cnt   <= TIMEOUT_CYCLES - 32'd1;
`endif
                    end
                end
                COLLECT: begin
                    if (clear) begin
                        state     <= IDLE;
                        digit_cnt <= '0;
                    end else if (press_stb) begin
                        digit_cnt <= digit_cnt + 4'd1;
                        match     <= match & sym_hit;
                        if (last_sym) state <= CHECK;
`ifdef PW_TIMEOUT_EN
                        tmo_cnt   <= TIMEOUT_CYCLES - 32'd1;
                    end else if (tmo_cnt == 32'd0) begin
                        // Abandoned entry is treated exactly like a wrong password.
                        pw_fail   <= 1'b1;
                        digit_cnt <= '0;
                        fail_cnt  <= fail_inc;
                        if (last_fail) begin
                            state    <= LOCKOUT;
                            lock_cnt <= LOCK_CYCLES - 32'd1;
                        end else begin
                            state    <= IDLE;
                        end
                    end else begin
                        tmo_cnt   <= tmo_cnt - 32'd1;
`endif
                    end
                end
                CHECK: begin
                    digit_cnt <= '0;
                    if (match) begin
                        pw_ok    <= 1'b1;
                        fail_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        pw_fail  <= 1'b1;
                        fail_cnt <= fail_inc;
                        if (last_fail) begin
                            state    <= LOCKOUT;
                            lock_cnt <= LOCK_CYCLES - 32'd1;
                        end else begin
                            state    <= IDLE;
                        end
                    end
                end
                LOCKOUT: begin
                    if (lock_cnt == 32'd0) begin
                        state    <= IDLE;
                        fail_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt - 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pw_check.sv
// Bench for pw_check: directed scenarios plus random entries, scored against a symbol-queue reference model.
// Latency: model applies the 3-edge input capture delay; outputs are compared every falling edge.
// Backpressure: n/a. Timeout scenario compiled only with PW_TIMEOUT_EN.
module tb_pw_check;

    localparam int          PW_LEN   = 4;
    localparam int          MAX_FAIL = 3;
    localparam int          LOCK     = 100;
    localparam int          TMO      = 50;

    logic       clk;
    logic       rst_n;
    logic [2:0] pwinput;
    logic       pw_entered;
    logic       clear;
    logic       pw_ok;
    logic       pw_fail;
    logic       locked;
    logic [3:0] digit_cnt;
    logic [2:0] fail_cnt;

    pw_check #(
        .PW_LEN         (PW_LEN),
        .PW_CODE        (12'b101_011_010_001),
        .MAX_FAIL       (MAX_FAIL),
        .LOCK_CYCLES    (32'(LOCK)),
        .TIMEOUT_CYCLES (32'(TMO))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwinput    (pwinput),
        .pw_entered (pw_entered),
        .clear      (clear),
        .pw_ok      (pw_ok),
        .pw_fail    (pw_fail),
        .locked     (locked),
        .digit_cnt  (digit_cnt),
        .fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int pw_sym [PW_LEN] = '{1, 2, 3, 5};   // L R U C
    int q[$];                             // symbols entered so far in this attempt
    bit pend = 0;                         // attempt complete, verdict on next edge
    bit in_lock = 0;
    int lock_left = 0;
    int fails = 0;
    int cyc = 0;
    int last_press = 0;
    bit e_ok = 0, e_fail = 0;
    bit h0 = 0, h1 = 0, h2 = 0;           // pw_entered as driven 1, 2, 3 edges ago
    int c0 = 0, c1 = 0;                   // pwinput as driven 1, 2 edges ago

    function automatic bit seq_ok();
        for (int i = 0; i < PW_LEN; i++)
            if (q[i] != pw_sym[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic fail_attempt();
        e_fail = 1;
        fails++;
        if (fails >= MAX_FAIL) begin
            in_lock   = 1;
            lock_left = LOCK;
        end
    endtask

    always @(posedge clk) begin
        bit press;
        int psym;
        e_ok   = 0;
        e_fail = 0;
        if (!rst_n) begin
            q.delete();
            pend = 0; in_lock = 0; lock_left = 0; fails = 0; cyc = 0; last_press = 0;
            h0 = 0; h1 = 0; h2 = 0; c0 = 0; c1 = 0;
        end else begin
            press = h1 && !h2;
            psym  = c1;
            cyc++;
            if (pend) begin
                pend = 0;
                if (seq_ok()) begin
                    e_ok  = 1;
                    fails = 0;
                end else begin
                    fail_attempt();
                end
                q.delete();
            end else if (in_lock) begin
                lock_left--;
                if (lock_left == 0) begin
                    in_lock = 0;
                    fails   = 0;
                end
            end else if (clear) begin
                q.delete();
            end else if (press) begin
                q.push_back(psym);
                last_press = cyc;
                if (q.size() == PW_LEN) pend = 1;
            end
`ifdef PW_TIMEOUT_EN
            else if (q.size() > 0 && (cyc - last_press) == TMO) begin
                fail_attempt();
                q.delete();
            end
`endif
            h2 = h1; h1 = h0; h0 = pw_entered;
            c1 = c0; c0 = int'(pwinput);
        end
    end

    // ---------------- continuous scoreboard ----------------
    bit chk_en = 0;
    int ok_seen = 0;
    int fail_seen = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("pw_ok", int'(pw_ok), int'(e_ok));
            check("pw_fail", int'(pw_fail), int'(e_fail));
            check("locked", int'(locked), int'(in_lock));
            check("digit_cnt", int'(digit_cnt), q.size());
            check("fail_cnt", int'(fail_cnt), fails);
            check("ok_fail_excl", int'(pw_ok & pw_fail), 0);
            if (pw_ok) ok_seen++;
            if (pw_fail) fail_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [2:0] code, input int hold, input int gap);
        @(negedge clk);
        pwinput    = code;
        pw_entered = 1'b1;
        repeat (hold) @(negedge clk);
        pw_entered = 1'b0;
        pwinput    = 3'd0;
        repeat (gap) @(negedge clk);
    endtask

    // Clear lands on the same edge the press would be captured.
    task automatic press_with_clear(input logic [2:0] code, input int gap);
        @(negedge clk);
        pwinput    = code;
        pw_entered = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        pw_entered = 1'b0;
        pwinput    = 3'd0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic correct_entry();
        for (int i = 0; i < PW_LEN; i++) press(3'(pw_sym[i]), 10, 10);
    endtask

    initial begin
        int sel;
        rst_n = 1'b0; pwinput = 3'd0; pw_entered = 1'b0; clear = 1'b0;
        chk_en = 1;

        // Reset: inputs wiggle, outputs must stay quiet.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pwinput    = 3'($urandom_range(0, 7));
            pw_entered = 1'($urandom_range(0, 1));
            clear      = 1'($urandom_range(0, 1));
            #1;
            check("rst_ok", int'(pw_ok), 0);
            check("rst_fail", int'(pw_fail), 0);
            check("rst_locked", int'(locked), 0);
            check("rst_digit", int'(digit_cnt), 0);
            check("rst_failcnt", int'(fail_cnt), 0);
        end
        @(negedge clk);
        pwinput = 3'd0; pw_entered = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b1;
        idle(5);

        // Correct entry.
        ok_seen = 0; fail_seen = 0;
        correct_entry();
        check("correct_ok_count", ok_seen, 1);
        check("correct_fail_count", fail_seen, 0);
        check("correct_failcnt", int'(fail_cnt), 0);

        // Clear after two symbols, then clear colliding with a press.
        ok_seen = 0; fail_seen = 0;
        press(3'd1, 5, 5);
        press(3'd2, 5, 5);
        check("pre_clear_digit", int'(digit_cnt), 2);
        pulse_clear();
        idle(3);
        check("clear_digit", int'(digit_cnt), 0);
        press_with_clear(3'd1, 5);
        check("clear_collide_digit", int'(digit_cnt), 0);
        correct_entry();
        check("clear_ok_count", ok_seen, 1);
        check("clear_fail_count", fail_seen, 0);

        // Illegal symbol in second position.
        fail_seen = 0;
        press(3'd1, 6, 6); press(3'd7, 6, 6); press(3'd3, 6, 6); press(3'd5, 6, 6);
        check("illegal_fail_count", fail_seen, 1);
        check("illegal_failcnt", int'(fail_cnt), 1);
        correct_entry();

        // Three wrong attempts -> lockout; presses ignored while locked.
        fail_seen = 0;
        for (int a = 0; a < 3; a++)
            for (int i = 0; i < PW_LEN; i++) press(3'd1, 4, 4);
        check("lock_fail_count", fail_seen, 3);
        check("lock_locked", int'(locked), 1);
        check("lock_failcnt", int'(fail_cnt), 3);
        press(3'd1, 5, 5);
        press(3'd2, 5, 5);
        check("lock_ignore_digit", int'(digit_cnt), 0);
        idle(LOCK);
        check("unlock_locked", int'(locked), 0);
        check("unlock_failcnt", int'(fail_cnt), 0);

`ifdef PW_TIMEOUT_EN
        // Abandoned entry times out.
        fail_seen = 0;
        press(3'd1, 10, 0);
        idle(60);
        check("tmo_fail_count", fail_seen, 1);
        check("tmo_digit", int'(digit_cnt), 0);
        check("tmo_failcnt", int'(fail_cnt), 1);
`endif

        // Long hold yields a single symbol.
        press(3'd1, 1000, 5);
`ifndef PW_TIMEOUT_EN
        check("hold_one_digit", int'(digit_cnt), 1);
`endif
        pulse_clear();
        correct_entry();

        // Reset mid-attempt.
        press(3'd1, 5, 5);
        press(3'd2, 5, 2);
        @(negedge clk); #2 rst_n = 1'b0;
        idle(2);
        check("midrst_digit", int'(digit_cnt), 0);
        @(negedge clk); #2 rst_n = 1'b1;
        idle(4);

        // Random entries: mostly-correct, random, clears and collisions.
        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                for (int i = 0; i < PW_LEN; i++)
                    press(3'(pw_sym[i]), $urandom_range(1, 12), $urandom_range(1, 12));
            end else if (sel < 7) begin
                for (int i = 0; i < PW_LEN; i++)
                    press(3'($urandom_range(0, 7)), $urandom_range(1, 12),
                          ($urandom_range(0, 15) == 0) ? 55 : $urandom_range(1, 12));
            end else if (sel < 9) begin
                press(3'(pw_sym[0]), $urandom_range(1, 8), $urandom_range(1, 8));
                pulse_clear();
            end else begin
                press_with_clear(3'($urandom_range(1, 5)), $urandom_range(1, 8));
            end
        end
        idle(LOCK + 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
